// File: rtl/test_logic_pkg.sv
// -----------------------------------------------------------------------------
// test_logic_pkg
// Shared definitions for the craps dice-game block:
//   - result_e    : registered game state encodings (init / reroll / win / lose)
//   - BLANK_DIE   : die code that blanks a seven-segment display
//   - SEG_*       : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - die_legal() : true for a die face value in 1..6
// -----------------------------------------------------------------------------
package test_logic_pkg;

    typedef enum logic [1:0] {
        RES_INIT   = 2'b00,
        RES_REROLL = 2'b01,
        RES_WIN    = 2'b10,
        RES_LOSE   = 2'b11
    } result_e;

    localparam logic [2:0] BLANK_DIE = 3'd7;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic die_legal(input logic [2:0] d);
        return (d != 3'd0) && (d != 3'd7);
    endfunction

endpackage

// File: rtl/test_logic_if.sv
// -----------------------------------------------------------------------------
// test_logic_if
// Bundles the dice-game request inputs and the registered/decoded outputs.
//   roll        : roll request level (rising edge = one throw)
//   die0, die1  : die face values, legal 1..6
//   sum         : die0+die1 of the last accepted roll
//   point       : current point, 0 when none
//   result      : game state 00 init, 01 reroll, 10 win, 11 lose
//   win, loss   : decoded from result
//   disp1/disp2 : active-low seven-segment patterns of the latched dice
// Modports: master drives the requests, slave is the game logic.
// -----------------------------------------------------------------------------
interface test_logic_if;

    logic       roll;
    logic [2:0] die0;
    logic [2:0] die1;
    logic [3:0] sum;
    logic [3:0] point;
    logic [1:0] result;
    logic       win;
    logic       loss;
    logic [6:0] disp1;
    logic [6:0] disp2;

    modport master (
        output roll, die0, die1,
        input  sum, point, result, win, loss, disp1, disp2
    );

    modport slave (
        input  roll, die0, die1,
        output sum, point, result, win, loss, disp1, disp2
    );

endinterface

// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational 3-bit value to active-low seven-segment pattern {g,f,e,d,c,b,a}.
//   value : 3-bit code; 7 is the blank code
//   seg   : active-low segment drive
// -----------------------------------------------------------------------------
module seven_seg_decoder
    import test_logic_pkg::*;
(
    input  logic [2:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/test_logic.sv
// -----------------------------------------------------------------------------
// test_logic
// Craps dice game. A rising edge on roll with both dice in 1..6 is one throw:
// the dice are latched for display, their sum is registered and the game rules
// advance the registered result/point.
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high, clears all state
//   bus    : test_logic_if.slave (roll, dice in; sum, point, result,
//            win, loss, disp1, disp2 out)
// -----------------------------------------------------------------------------
module test_logic
    import test_logic_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    test_logic_if.slave  bus
);

    logic       roll_q,  roll_d;
    logic [2:0] die0_q,  die0_d;
    logic [2:0] die1_q,  die1_d;
    logic [3:0] sum_q,   sum_d;
    logic [3:0] point_q, point_d;
    result_e    result_q, result_d;

    logic       accept;
    logic [3:0] roll_sum;

    // Edge detect, dice legality and game rules
    always_comb begin
        roll_d   = bus.roll;
        roll_sum = {1'b0, bus.die0} + {1'b0, bus.die1};
        // reset gating keeps a roll edge coincident with reset from counting
        accept   = bus.roll & ~roll_q & die_legal(bus.die0)
                 & die_legal(bus.die1) & ~reset;

        die0_d   = die0_q;
        die1_d   = die1_q;
        sum_d    = sum_q;
        point_d  = point_q;
        result_d = result_q;

        if (accept) begin
            die0_d = bus.die0;
            die1_d = bus.die1;
            sum_d  = roll_sum;
            if (result_q == RES_REROLL) begin
                // point is kept whatever the outcome of a reroll
                if (roll_sum == point_q) begin
                    result_d = RES_WIN;
                end else if (roll_sum == 4'd7) begin
                    result_d = RES_LOSE;
                end
            end else begin
                // init, win and lose all treat this throw as a new game's first
                if (roll_sum == 4'd7 || roll_sum == 4'd11) begin
                    result_d = RES_WIN;
                    point_d  = 4'd0;
                end else if (roll_sum == 4'd2 || roll_sum == 4'd3 || roll_sum == 4'd12) begin
                    result_d = RES_LOSE;
                    point_d  = 4'd0;
                end else begin
                    result_d = RES_REROLL;
                    point_d  = roll_sum;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            // roll_q tracks roll through reset so a level held across it is not an edge
            roll_q   <= bus.roll;
            die0_q   <= BLANK_DIE;
            die1_q   <= BLANK_DIE;
            sum_q    <= 4'd0;
            point_q  <= 4'd0;
            result_q <= RES_INIT;
        end else begin
            roll_q   <= roll_d;
            die0_q   <= die0_d;
            die1_q   <= die1_d;
            sum_q    <= sum_d;
            point_q  <= point_d;
            result_q <= result_d;
        end
    end

    // Output decode
    seven_seg_decoder u_dec0 (
        .value (die0_q),
        .seg   (bus.disp1)
    );

    seven_seg_decoder u_dec1 (
        .value (die1_q),
        .seg   (bus.disp2)
    );

    assign bus.sum    = sum_q;
    assign bus.point  = point_q;
    assign bus.result = result_q;
    assign bus.win    = (result_q == RES_WIN);
    assign bus.loss   = (result_q == RES_LOSE);

endmodule

// File: tb/tb_test_logic.sv
// -----------------------------------------------------------------------------
// tb_test_logic
// Self-checking bench for test_logic: directed game scenarios checked against
// literal values, then randomized throws checked every cycle against a
// behavioural game model.
// -----------------------------------------------------------------------------
module tb_test_logic;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    test_logic_if bus ();

    test_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] seg_tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111111};

    // Behavioural game model
    int   m_d0 = 7, m_d1 = 7, m_sum = 0, m_point = 0, m_res = 0;
    logic m_prev = 1'b0;

    task automatic model_step(input logic r, input int d0, input int d1, input logic rst);
        int s;
        if (rst) begin
            m_d0 = 7; m_d1 = 7; m_sum = 0; m_point = 0; m_res = 0;
        end else if (r && !m_prev && d0 >= 1 && d0 <= 6 && d1 >= 1 && d1 <= 6) begin
            s = d0 + d1;
            m_d0 = d0; m_d1 = d1; m_sum = s;
            if (m_res == 1) begin
                if (s == m_point) m_res = 2;
                else if (s == 7)  m_res = 3;
            end else if (s == 7 || s == 11) begin
                m_res = 2; m_point = 0;
            end else if (s == 2 || s == 3 || s == 12) begin
                m_res = 3; m_point = 0;
            end else begin
                m_res = 1; m_point = s;
            end
        end
        m_prev = r;
    endtask

    // One clock: inputs were set on the falling edge, model sees them at the
    // rising edge, outputs are sampled back on the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(bus.roll, int'(bus.die0), int'(bus.die1), reset);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.roll = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic roll_dice(input logic [2:0] d0, input logic [2:0] d1);
        bus.die0 = d0; bus.die1 = d1; bus.roll = 1'b1;
        tick();
        bus.roll = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.roll = 1'b1; bus.die0 = 3'd3; bus.die1 = 3'd4;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; bus.roll = 1'b0;
        tick();
        n_cmp++; if (bus.result !== 2'b00) begin n_fail++; $display("FAIL reset_result got %b want 00", bus.result); end
        n_cmp++; if (bus.sum !== 4'd0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", bus.sum); end
        n_cmp++; if (bus.point !== 4'd0) begin n_fail++; $display("FAIL reset_point got %0d want 0", bus.point); end
        n_cmp++; if ({bus.win, bus.loss} !== 2'b00) begin n_fail++; $display("FAIL reset_winloss got %b want 00", {bus.win, bus.loss}); end
        n_cmp++; if ({bus.disp1, bus.disp2} !== {7'b1111111, 7'b1111111}) begin n_fail++; $display("FAIL reset_disp got %b %b want 1111111 1111111", bus.disp1, bus.disp2); end
    endtask

    task automatic test_natural_win();
        do_reset();
        roll_dice(3'd3, 3'd4);
        n_cmp++; if (bus.result !== 2'b10) begin n_fail++; $display("FAIL win7_result got %b want 10", bus.result); end
        n_cmp++; if ({bus.win, bus.loss} !== 2'b10) begin n_fail++; $display("FAIL win7_winloss got %b want 10", {bus.win, bus.loss}); end
        n_cmp++; if (bus.sum !== 4'd7 || bus.point !== 4'd0) begin n_fail++; $display("FAIL win7_sum_point got %0d/%0d want 7/0", bus.sum, bus.point); end
        n_cmp++; if (bus.disp1 !== 7'b0110000 || bus.disp2 !== 7'b0011001) begin n_fail++; $display("FAIL win7_disp got %b %b want 0110000 0011001", bus.disp1, bus.disp2); end
    endtask

    task automatic test_craps_then_new_game();
        do_reset();
        roll_dice(3'd1, 3'd1);
        n_cmp++; if (bus.result !== 2'b11 || bus.loss !== 1'b1 || bus.win !== 1'b0) begin n_fail++; $display("FAIL craps2_result got %b loss=%b win=%b want 11 1 0", bus.result, bus.loss, bus.win); end
        n_cmp++; if (bus.sum !== 4'd2) begin n_fail++; $display("FAIL craps2_sum got %0d want 2", bus.sum); end
        roll_dice(3'd5, 3'd6);
        n_cmp++; if (bus.result !== 2'b10 || bus.win !== 1'b1) begin n_fail++; $display("FAIL newgame11_result got %b win=%b want 10 1", bus.result, bus.win); end
        n_cmp++; if (bus.sum !== 4'd11) begin n_fail++; $display("FAIL newgame11_sum got %0d want 11", bus.sum); end
    endtask

    task automatic test_point_made();
        do_reset();
        roll_dice(3'd2, 3'd2);
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd4) begin n_fail++; $display("FAIL point4_set got %b/%0d want 01/4", bus.result, bus.point); end
        roll_dice(3'd1, 3'd2);
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd4 || bus.sum !== 4'd3) begin n_fail++; $display("FAIL point4_reroll got %b/%0d/%0d want 01/4/3", bus.result, bus.point, bus.sum); end
        roll_dice(3'd3, 3'd1);
        n_cmp++; if (bus.result !== 2'b10 || bus.point !== 4'd4 || bus.win !== 1'b1) begin n_fail++; $display("FAIL point4_made got %b/%0d win=%b want 10/4 1", bus.result, bus.point, bus.win); end
    endtask

    task automatic test_seven_out();
        do_reset();
        roll_dice(3'd4, 3'd5);
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd9) begin n_fail++; $display("FAIL point9_set got %b/%0d want 01/9", bus.result, bus.point); end
        roll_dice(3'd6, 3'd1);
        n_cmp++; if (bus.result !== 2'b11 || bus.loss !== 1'b1 || bus.point !== 4'd9) begin n_fail++; $display("FAIL sevenout got %b loss=%b point=%0d want 11 1 9", bus.result, bus.loss, bus.point); end
    endtask

    task automatic test_held_and_illegal();
        logic [2:0] vals0 [10] = '{3'd2, 3'd3, 3'd1, 3'd6, 3'd5, 3'd4, 3'd3, 3'd6, 3'd1, 3'd2};
        logic [2:0] vals1 [10] = '{3'd3, 3'd4, 3'd4, 3'd1, 3'd5, 3'd3, 3'd2, 3'd6, 3'd6, 3'd5};
        do_reset();
        bus.roll = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.die0 = vals0[i]; bus.die1 = vals1[i];
            tick();
        end
        bus.roll = 1'b0;
        tick();
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd5 || bus.sum !== 4'd5) begin n_fail++; $display("FAIL held_once got %b/%0d/%0d want 01/5/5", bus.result, bus.point, bus.sum); end
        n_cmp++; if (bus.disp1 !== 7'b0100100 || bus.disp2 !== 7'b0110000) begin n_fail++; $display("FAIL held_disp got %b %b want 0100100 0110000", bus.disp1, bus.disp2); end
        roll_dice(3'd0, 3'd3);
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd5 || bus.sum !== 4'd5 || bus.disp1 !== 7'b0100100) begin n_fail++; $display("FAIL die0_zero got %b/%0d/%0d/%b want 01/5/5/0100100", bus.result, bus.point, bus.sum, bus.disp1); end
        roll_dice(3'd4, 3'd7);
        n_cmp++; if (bus.result !== 2'b01 || bus.sum !== 4'd5 || bus.disp2 !== 7'b0110000) begin n_fail++; $display("FAIL die1_seven got %b/%0d/%b want 01/5/0110000", bus.result, bus.sum, bus.disp2); end
    endtask

    task automatic test_reset_mid_game();
        do_reset();
        roll_dice(3'd3, 3'd3);
        n_cmp++; if (bus.result !== 2'b01 || bus.point !== 4'd6) begin n_fail++; $display("FAIL midreset_setup got %b/%0d want 01/6", bus.result, bus.point); end
        bus.die0 = 3'd1; bus.die1 = 3'd1; bus.roll = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; bus.roll = 1'b0;
        tick();
        n_cmp++; if (bus.result !== 2'b00 || bus.point !== 4'd0 || bus.sum !== 4'd0) begin n_fail++; $display("FAIL midreset_state got %b/%0d/%0d want 00/0/0", bus.result, bus.point, bus.sum); end
        n_cmp++; if (bus.disp1 !== 7'b1111111 || bus.disp2 !== 7'b1111111 || bus.win !== 1'b0 || bus.loss !== 1'b0) begin n_fail++; $display("FAIL midreset_disp got %b %b w=%b l=%b want blank 0 0", bus.disp1, bus.disp2, bus.win, bus.loss); end
    endtask

    task automatic test_random();
        logic [1:0] exp_res;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            bus.roll = ($urandom_range(0, 1) == 1);
            // mostly legal dice, occasionally 0 or 7
            bus.die0 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
            bus.die1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
            tick();
            exp_res = 2'(m_res);
            n_cmp++;
            if (bus.result !== exp_res || bus.sum !== 4'(m_sum) || bus.point !== 4'(m_point)
                || bus.win !== (m_res == 2) || bus.loss !== (m_res == 3)
                || bus.disp1 !== seg_tbl[m_d0] || bus.disp2 !== seg_tbl[m_d1]) begin
                n_fail++;
                $display("FAIL random_cycle%0d got res=%b sum=%0d pt=%0d w=%b l=%b d1=%b d2=%b want res=%b sum=%0d pt=%0d d1=%b d2=%b",
                         i, bus.result, bus.sum, bus.point, bus.win, bus.loss, bus.disp1, bus.disp2,
                         exp_res, m_sum, m_point, seg_tbl[m_d0], seg_tbl[m_d1]);
            end
        end
        reset = 1'b0; bus.roll = 1'b0;
    endtask

    initial begin
        bus.roll = 1'b0; bus.die0 = 3'd1; bus.die1 = 3'd1;
        @(negedge clk);
        test_reset();
        test_natural_win();
        test_craps_then_new_game();
        test_point_made();
        test_seven_out();
        test_held_and_illegal();
        test_reset_mid_game();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/test_logic.md
TEST_LOGIC -- requirements
Module: test_logic

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 Single clock: clock input 1, all state updates on rising edge; reset is synchronous and active-high.
REQ-003 reset  input  1  synchronous, active-high; clears all state.
REQ-004 roll  input  1  roll request level; a rising edge (sampled on clock) means one dice throw.
REQ-005 die0  input  3  first die value, legal 1..6.
REQ-006 die1  input  3  second die value, legal 1..6.
REQ-007 sum  output  4  registered die0+die1 of last accepted roll.
REQ-008 point  output  4  registered current point; 0 when no point set.
REQ-009 result  output  2  registered game state: 00 init, 01 reroll (point established), 10 win, 11 lose.
REQ-010 win  output  1  high exactly when result==10.
REQ-011 loss  output  1  high exactly when result==11.
REQ-012 disp1  output  7  active-low segments {g,f,e,d,c,b,a} for latched die0.
REQ-013 disp2  output  7  active-low segments for latched die1.

Function
REQ-014 roll_q register stores previous roll; accepted roll = roll & !roll_q & both dice in 1..6 & !reset.
REQ-015 Roll with any die 0 or 7 is ignored entirely: no latch, no state change.
REQ-016 On accepted roll: latch die0/die1 into display registers, sum <= die0+die1 (4-bit, zero-extended, no overflow, max 12); all updates visible the cycle after the edge.
REQ-017 From init (also from win/lose: next accepted roll starts new game): sum 7 or 11 -> win, point <= 0; sum 2, 3 or 12 -> lose, point <= 0; otherwise -> reroll, point <= sum.
REQ-018 From reroll: sum == point -> win; sum == 7 -> lose; else stay reroll; point unchanged in all three cases.
REQ-019 Point holds its value through win/lose until next game's first roll overwrites or clears it.
REQ-020 Level-high roll held across many cycles counts once; no new roll until roll returns low for at least one cycle.
REQ-021 Decoder map: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111111 (blank).
REQ-022 disp1/disp2 combinational from latched dice registers; zero added latency beyond the latch.
REQ-023 win/loss combinational from result register; never both high.

Reset
REQ-024 On clock edge with reset=1: latched dice <= 7 (displays blank 1111111), sum <= 0, point <= 0, result <= 00, roll_q <= roll; win=loss=0.
REQ-025 Reset overrides a simultaneous roll edge; the roll is discarded.
REQ-026 Reset mid-game (reroll state) discards point and returns to init.

Structure
REQ-027 Shared package: result encodings (INIT, REROLL, WIN, LOSE), BLANK die code 3'd7, seven-segment pattern constants.
REQ-028 One sub-module seven_seg_decoder (3-bit in, 7-bit out, combinational), instantiated twice; adder and rule logic inline.

Verification
REQ-029 Reset, then roll 3+4 -> result=10, win=1, sum=7, point=0, disp1=0110000, disp2=0011001.
REQ-030 Reset, roll 1+1 -> result=11, loss=1, sum=2; next roll 5+6 -> new game, win, sum=11.
REQ-031 Reset, roll 2+2 -> result=01, point=4; roll 1+2 -> stays 01; roll 3+1 -> result=10, point stays 4.
REQ-032 Reset, roll 4+5 -> point=9; roll 6+1 -> result=11, loss=1.
REQ-033 Roll held high 10 cycles with changing dice -> exactly one accepted roll; roll with die0=0 -> no change.
REQ-034 Reset asserted same cycle as roll edge in reroll state -> result=00, point=0, displays 1111111.
